// File: rtl/lia_ctrl_regbank_if.sv
// Avalon-MM slave bus bundle for the lock-in control register bank.
interface lia_ctrl_regbank_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata, avs_readdatavalid
  );
  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/lia_ctrl_regbank.sv
// Lock-in array register bank: shadowed NCO phase regs with coherent commit, X/Y snapshot, gains.
// Optional LIA_AUTO_SNAPSHOT_EN: every res_valid captures, arming is disabled.
module lia_ctrl_regbank_ch #(
  parameter int PHASE_W = 20,
  parameter int RES_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_incr_i,
  input  logic               wr_offs_i,
  input  logic [PHASE_W-1:0] wdata_i,
  input  logic               apply_i,
  input  logic               capture_i,
  input  logic [RES_W-1:0]   x_i,
  input  logic [RES_W-1:0]   y_i,
  output logic [PHASE_W-1:0] incr_sh_o,
  output logic [PHASE_W-1:0] offs_sh_o,
  output logic [PHASE_W-1:0] incr_o,
  output logic [PHASE_W-1:0] offs_o,
  output logic [RES_W-1:0]   x_rd_o,
  output logic [RES_W-1:0]   y_rd_o
);
  logic [PHASE_W-1:0] incr_sh_q, offs_sh_q, incr_q, offs_q;
  logic [RES_W-1:0]   x_q, y_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      incr_sh_q <= '0; offs_sh_q <= '0;
      incr_q    <= '0; offs_q    <= '0;
      x_q       <= '0; y_q       <= '0;
    end else begin
      if (wr_incr_i) incr_sh_q <= wdata_i;
      if (wr_offs_i) offs_sh_q <= wdata_i;
      // apply copies the pre-write shadow, so a same-cycle bus write waits for the next commit
      if (apply_i) begin
        incr_q <= incr_sh_q;
        offs_q <= offs_sh_q;
      end
      if (capture_i) begin
        x_q <= x_i;
        y_q <= y_i;
      end
    end
  end

  assign incr_sh_o = incr_sh_q;
  assign offs_sh_o = offs_sh_q;
  assign incr_o    = incr_q;
  assign offs_o    = offs_q;
  // bypass lets a read issued on the capture edge already see the new sample
  assign x_rd_o    = capture_i ? x_i : x_q;
  assign y_rd_o    = capture_i ? y_i : y_q;
endmodule

module lia_ctrl_regbank #(
  parameter int NUM_CH  = 8,
  parameter int PHASE_W = 20,
  parameter int RES_W   = 16,
  parameter int ADDR_W  = 6
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  lia_ctrl_regbank_if.slave         avs,
  input  logic                      sample_stb,
  input  logic                      res_valid,
  input  logic [NUM_CH*RES_W-1:0]   lia_x,
  input  logic [NUM_CH*RES_W-1:0]   lia_y,
  output logic [NUM_CH*PHASE_W-1:0] phase_incr,
  output logic [NUM_CH*PHASE_W-1:0] phase_offs,
  output logic [7:0]                dac_gain,
  output logic [5:0]                gain_ctrl,
  output logic                      commit_pending
);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(NUM_CH*4);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_CH*4 + 1);
  localparam logic [ADDR_W-1:0] A_DAC  = ADDR_W'(NUM_CH*4 + 2);
  localparam logic [ADDR_W-1:0] A_GAIN = ADDR_W'(NUM_CH*4 + 3);

  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              unused_wdata;
  assign addr         = avs.avs_address;
  assign wdata        = avs.avs_writedata;
  assign unused_wdata = ^wdata;

  logic [NUM_CH-1:0][PHASE_W-1:0] incr_sh, offs_sh, incr_act, offs_act;
  logic [NUM_CH-1:0][RES_W-1:0]   x_rd, y_rd;
  logic [NUM_CH-1:0]              wr_incr, wr_offs;

  logic       pend_q, pend_d, armed_q, armed_d, snapv_q, snapv_d, ovr_q, ovr_d;
  logic [7:0] dac_q, dac_d;
  logic [5:0] gain_q, gain_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic        ctrl_wr, stat_wr, apply, capture;

  assign ctrl_wr = avs.avs_write && (addr == A_CTRL);
  assign stat_wr = avs.avs_write && (addr == A_STAT);
  assign apply   = sample_stb && pend_q;
`ifdef LIA_AUTO_SNAPSHOT_EN
  assign capture = res_valid;
`else
  assign capture = res_valid && armed_q;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_incr[g] = avs.avs_write && (addr == ADDR_W'(g*4));
    assign wr_offs[g] = avs.avs_write && (addr == ADDR_W'(g*4 + 1));
    lia_ctrl_regbank_ch #(.PHASE_W(PHASE_W), .RES_W(RES_W)) u_ch (
      .clk_i     (clk_clk),
      .rst_ni    (reset_reset_n),
      .wr_incr_i (wr_incr[g]),
      .wr_offs_i (wr_offs[g]),
      .wdata_i   (wdata[PHASE_W-1:0]),
      .apply_i   (apply),
      .capture_i (capture),
      .x_i       (lia_x[g*RES_W +: RES_W]),
      .y_i       (lia_y[g*RES_W +: RES_W]),
      .incr_sh_o (incr_sh[g]),
      .offs_sh_o (offs_sh[g]),
      .incr_o    (incr_act[g]),
      .offs_o    (offs_act[g]),
      .x_rd_o    (x_rd[g]),
      .y_rd_o    (y_rd[g])
    );
  end

  always_comb begin
    // a commit write on the applying strobe is absorbed; one on a non-pending strobe arms the next
    pend_d  = apply ? 1'b0 : (pend_q | (ctrl_wr & wdata[0]));
`ifdef LIA_AUTO_SNAPSHOT_EN
    armed_d = 1'b0;
`else
    armed_d = (armed_q & ~capture) | (ctrl_wr & wdata[1]);
`endif
    snapv_d = capture | (snapv_q & ~(stat_wr & wdata[1]));
    ovr_d   = (capture & snapv_q) | (ovr_q & ~(stat_wr & wdata[2]));
    dac_d   = (avs.avs_write && addr == A_DAC)  ? wdata[7:0] : dac_q;
    gain_d  = (avs.avs_write && addr == A_GAIN) ? wdata[5:0] : gain_q;
  end

  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr == ADDR_W'(c*4))     rdata_d = 32'(incr_sh[c]);
      if (addr == ADDR_W'(c*4 + 1)) rdata_d = 32'(offs_sh[c]);
      if (addr == ADDR_W'(c*4 + 2)) rdata_d = 32'($signed(x_rd[c]));
      if (addr == ADDR_W'(c*4 + 3)) rdata_d = 32'($signed(y_rd[c]));
    end
    if (addr == A_STAT) rdata_d = {28'd0, armed_q, ovr_q, snapv_q, pend_q};
    if (addr == A_DAC)  rdata_d = {24'd0, dac_q};
    if (addr == A_GAIN) rdata_d = {26'd0, gain_q};
    if (!avs.avs_read)  rdata_d = '0;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend_q <= 1'b0; armed_q <= 1'b0; snapv_q <= 1'b0; ovr_q <= 1'b0;
      dac_q  <= '0;   gain_q  <= '0;
      rdata_q <= '0;  rvalid_q <= 1'b0;
    end else begin
      pend_q <= pend_d; armed_q <= armed_d; snapv_q <= snapv_d; ovr_q <= ovr_d;
      dac_q  <= dac_d;  gain_q  <= gain_d;
      rdata_q <= rdata_d; rvalid_q <= avs.avs_read;
    end
  end

  assign phase_incr            = incr_act;
  assign phase_offs            = offs_act;
  assign dac_gain              = dac_q;
  assign gain_ctrl             = gain_q;
  assign commit_pending        = pend_q;
  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;
endmodule

// File: tb/tb_lia_ctrl_regbank.sv
// Scoreboard bench for lia_ctrl_regbank (default manual-snapshot build).
module tb_lia_ctrl_regbank;
  localparam int NUM_CH = 8, PHASE_W = 20, RES_W = 16, ADDR_W = 6;
  localparam int G = NUM_CH*4;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic sample_stb = 1'b0, res_valid = 1'b0;
  logic [NUM_CH*RES_W-1:0]   lia_x = '0, lia_y = '0;
  logic [NUM_CH*PHASE_W-1:0] phase_incr, phase_offs, exp_incr;
  logic [7:0] dac_gain;
  logic [5:0] gain_ctrl;
  logic       commit_pending;

  lia_ctrl_regbank_if #(.ADDR_W(ADDR_W)) avs();

  lia_ctrl_regbank #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .avs(avs),
    .sample_stb(sample_stb), .res_valid(res_valid), .lia_x(lia_x), .lia_y(lia_y),
    .phase_incr(phase_incr), .phase_offs(phase_offs), .dac_gain(dac_gain),
    .gain_ctrl(gain_ctrl), .commit_pending(commit_pending)
  );

  always #5 clk_clk = ~clk_clk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  int          addr_q[$];

  // scoreboard: every readdatavalid pops one expected value
  always @(negedge clk_clk) begin
    if (avs.avs_readdatavalid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rdvalid: readdata=%h with no read outstanding", avs.avs_readdata);
      end else begin
        logic [31:0] e;
        int a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (avs.avs_readdata !== e) begin
          n_fail++;
          $display("FAIL read_addr%0d: got %h expected %h", a, avs.avs_readdata, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk_clk);
    avs.avs_address = ADDR_W'(a); avs.avs_writedata = d; avs.avs_write = 1'b1;
    @(negedge clk_clk);
    avs.avs_write = 1'b0;
  endtask

  task automatic bus_read(input int a, input logic [31:0] e);
    @(negedge clk_clk);
    avs.avs_address = ADDR_W'(a); avs.avs_read = 1'b1;
    exp_q.push_back(e); addr_q.push_back(a);
    @(negedge clk_clk);
    avs.avs_read = 1'b0;
  endtask

  task automatic pulse_stb();
    @(negedge clk_clk); sample_stb = 1'b1;
    @(negedge clk_clk); sample_stb = 1'b0;
  endtask

  task automatic pulse_res();
    @(negedge clk_clk); res_valid = 1'b1;
    @(negedge clk_clk); res_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({phase_incr, phase_offs, dac_gain, gain_ctrl, commit_pending,
         avs.avs_readdata, avs.avs_readdatavalid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: some output nonzero incr=%h offs=%h dac=%h gain=%h pend=%b",
               phase_incr, phase_offs, dac_gain, gain_ctrl, commit_pending);
    end
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    avs.avs_address = ADDR_W'(G+1); avs.avs_read = 1'b1;
    exp_q.push_back(32'h0); addr_q.push_back(G+1);
    @(negedge clk_clk);
    avs.avs_read = 1'b0;
    n_chk++;
    if (avs.avs_readdatavalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rdvalid_latency: got %b expected 1 one cycle after read", avs.avs_readdatavalid);
    end
    @(negedge clk_clk);
    n_chk++;
    if (avs.avs_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdvalid_pulse: got %b expected 0 two cycles after read", avs.avs_readdatavalid);
    end
  endtask

  task automatic test_commit();
    exp_incr = '0;
    bus_write(3*4, 32'h0001_2345);
    bus_write(G, 32'h1);
    n_chk++;
    if (commit_pending !== 1'b1 || phase_incr !== '0) begin
      n_fail++;
      $display("FAIL commit_armed: pend=%b incr=%h expected pend=1 incr=0", commit_pending, phase_incr);
    end
    bus_read(G+1, 32'h1);
    repeat (5) @(negedge clk_clk);
    n_chk++;
    if (commit_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_hold: pend=%b expected 1", commit_pending);
    end
    pulse_stb();
    exp_incr[3*PHASE_W +: PHASE_W] = 20'h12345;
    n_chk++;
    if (phase_incr !== exp_incr || commit_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_apply: incr=%h pend=%b expected incr=%h pend=0", phase_incr, commit_pending, exp_incr);
    end
    bus_read(3*4, 32'h0001_2345);
  endtask

  task automatic test_commit_coincident();
    bus_write(1*4, 32'h000A_BCDE);
    @(negedge clk_clk);
    avs.avs_address = ADDR_W'(G); avs.avs_writedata = 32'h1; avs.avs_write = 1'b1; sample_stb = 1'b1;
    @(negedge clk_clk);
    avs.avs_write = 1'b0; sample_stb = 1'b0;
    n_chk++;
    if (phase_incr !== exp_incr || commit_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_coincident: incr=%h pend=%b expected incr=%h pend=1", phase_incr, commit_pending, exp_incr);
    end
    // shadow write on the applying strobe: active must take the old shadow
    @(negedge clk_clk);
    avs.avs_address = ADDR_W'(1*4); avs.avs_writedata = 32'h0001_1111; avs.avs_write = 1'b1; sample_stb = 1'b1;
    @(negedge clk_clk);
    avs.avs_write = 1'b0; sample_stb = 1'b0;
    exp_incr[1*PHASE_W +: PHASE_W] = 20'hABCDE;
    n_chk++;
    if (phase_incr !== exp_incr || commit_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_next_stb: incr=%h pend=%b expected incr=%h pend=0", phase_incr, commit_pending, exp_incr);
    end
    bus_read(1*4, 32'h0001_1111);
  endtask

  task automatic test_snapshot();
    bus_write(G, 32'h2);
    bus_read(G+1, 32'h8);
    lia_x[0 +: RES_W] = 16'h8001;
    lia_y[5*RES_W +: RES_W] = 16'h0123;
    pulse_res();
    bus_read(2, 32'hFFFF_8001);
    bus_read(5*4+3, 32'h0000_0123);
    bus_read(G+1, 32'h2);
    lia_x[0 +: RES_W] = 16'h1234;
    pulse_res();
    bus_read(2, 32'hFFFF_8001);
    bus_write(G, 32'h2);
    pulse_res();
    bus_read(G+1, 32'h6);
    bus_read(2, 32'h0000_1234);
    bus_write(G+1, 32'h6);
    bus_read(G+1, 32'h0);
    // read issued on the capture edge sees the new sample
    bus_write(G, 32'h2);
    @(negedge clk_clk);
    lia_x[0 +: RES_W] = 16'h7FFF;
    res_valid = 1'b1; avs.avs_address = ADDR_W'(2); avs.avs_read = 1'b1;
    exp_q.push_back(32'h0000_7FFF); addr_q.push_back(2);
    @(negedge clk_clk);
    res_valid = 1'b0; avs.avs_read = 1'b0;
    // W1C coincident with a capture: the set wins
    bus_write(G, 32'h2);
    @(negedge clk_clk);
    res_valid = 1'b1; avs.avs_address = ADDR_W'(G+1); avs.avs_writedata = 32'h6; avs.avs_write = 1'b1;
    @(negedge clk_clk);
    res_valid = 1'b0; avs.avs_write = 1'b0;
    bus_read(G+1, 32'h6);
  endtask

  task automatic test_rw_unmapped();
    bus_write(7*4+1, 32'hFFFF_FFFF);
    bus_write(G+2, 32'hFFFF_FFFF);
    bus_write(G+3, 32'hFFFF_FFFF);
    bus_write(G+4, 32'hFFFF_FFFF);
    bus_write(2, 32'h0000_0055);
    n_chk++;
    if (dac_gain !== 8'hFF || gain_ctrl !== 6'h3F) begin
      n_fail++;
      $display("FAIL gain_outputs: dac=%h gain=%h expected ff 3f", dac_gain, gain_ctrl);
    end
    n_chk++;
    if (phase_offs !== '0) begin
      n_fail++;
      $display("FAIL offs_not_shadowed: offs=%h expected 0 before commit", phase_offs);
    end
    bus_read(2, 32'h0000_7FFF);
    bus_read(G, 32'h0);
  endtask

  task automatic test_back_to_back();
    int a[6] = '{7*4+1, G+2, G+3, G+4, 63, 7*4};
    logic [31:0] e[6] = '{32'h000F_FFFF, 32'hFF, 32'h3F, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_clk);
      avs.avs_address = ADDR_W'(a[i]); avs.avs_read = 1'b1;
      exp_q.push_back(e[i]); addr_q.push_back(a[i]);
    end
    @(negedge clk_clk);
    avs.avs_read = 1'b0;
  endtask

  task automatic test_async_reset();
    bus_write(G, 32'h1);
    @(negedge clk_clk);
    avs.avs_address = ADDR_W'(G+2); avs.avs_read = 1'b1;
    @(posedge clk_clk);
    #2;
    n_chk++;
    if (avs.avs_readdatavalid !== 1'b1 || commit_pending !== 1'b1 || phase_incr === '0) begin
      n_fail++;
      $display("FAIL pre_reset_state: rdvalid=%b pend=%b incr=%h expected 1 1 nonzero",
               avs.avs_readdatavalid, commit_pending, phase_incr);
    end
    reset_reset_n = 1'b0;
    #1;
    n_chk++;
    if (avs.avs_readdatavalid !== 1'b0 || avs.avs_readdata !== '0 || commit_pending !== 1'b0 ||
        phase_incr !== '0 || dac_gain !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdvalid=%b rdata=%h pend=%b incr=%h dac=%h expected all 0",
               avs.avs_readdatavalid, avs.avs_readdata, commit_pending, phase_incr, dac_gain);
    end
    @(negedge clk_clk);
    avs.avs_read = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    bus_read(G+1, 32'h0);
    bus_read(7*4+1, 32'h0);
  endtask

  initial begin
    avs.avs_address = '0; avs.avs_write = 1'b0; avs.avs_writedata = '0; avs.avs_read = 1'b0;
    exp_incr = '0;
    test_reset();
    test_commit();
    test_commit_coincident();
    test_snapshot();
    test_rw_unmapped();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(negedge clk_clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reads_outstanding: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
